// File: rtl/orion_mem_pkg.sv
// Shared types for the spram initiator: access sizes, FSM states, byte-mask width
// and the misalignment predicate.
package orion_mem_pkg;

    localparam int MASKW = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RSP   = 2'b11
    } spram_init_state_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_HALF: mis = off[0];
            MEM_WORD: mis = (off != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/spram_lane_align.sv
// Combinational byte-lane steering: store mask/data placement and load lane
// extraction with sign or zero extension.
module spram_lane_align
    import orion_mem_pkg::*;
(
    input  mem_size_e         size_i,
    input  logic [1:0]        off_i,
    input  logic              unsigned_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       rdata_i,
    output logic [MASKW-1:0]  mask_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       rdata_o
);

    logic [31:0] lane_s;
    logic        sign_s;

    // Shift by the byte offset, then extend according to the access size.
    always_comb begin
        lane_s  = rdata_i >> {off_i, 3'b000};
        wdata_o = wdata_i << {off_i, 3'b000};
        mask_o  = 4'b1111;
        rdata_o = lane_s;
        sign_s  = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                mask_o  = 4'b0001 << off_i;
                sign_s  = ~unsigned_i & lane_s[7];
                rdata_o = {{24{sign_s}}, lane_s[7:0]};
            end
            MEM_HALF: begin
                mask_o  = 4'b0011 << off_i;
                sign_s  = ~unsigned_i & lane_s[15];
                rdata_o = {{16{sign_s}}, lane_s[15:0]};
            end
            default: begin
                mask_o  = 4'b1111;
                rdata_o = lane_s;
            end
        endcase
    end

endmodule

// File: rtl/spram_initiator.sv
// Single-outstanding load/store master for one spram port.
// Optional SPRAM_INITIATOR_MISALIGN_CHK_EN: fault misaligned half/word accesses instead of truncating.
module spram_initiator
    import orion_mem_pkg::*;
#(
    parameter int ADDRW     = 32,
    parameter int MEM_ADDRW = 10,
    parameter int DATAW     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ADDRW-1:0]     req_addr_i,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [DATAW-1:0]     req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAW-1:0]     rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [MEM_ADDRW-1:0] mem_addr_o,
    output logic [DATAW-1:0]     mem_data_o,
    output logic [MASKW-1:0]     mem_mask_o,
    output logic                 mem_we_o,
    output logic                 mem_valid_o,
    input  logic [DATAW-1:0]     mem_data_i,
    input  logic                 mem_resp_i
);

    spram_init_state_e    state_q, state_d;
    logic [MEM_ADDRW-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    mem_size_e            size_q, size_d;
    logic                 uns_q, uns_d;
    logic [DATAW-1:0]     wdata_q, wdata_d;
    logic [DATAW-1:0]     rdata_q, rdata_d;
    logic                 err_q, err_d;

    mem_size_e            size_norm_s;
    logic [MASKW-1:0]     mask_s;
    logic [DATAW-1:0]     wdata_al_s;
    logic [DATAW-1:0]     load_s;
    logic                 issue_s;
    logic                 unused_addr_s;

    assign unused_addr_s = ^req_addr_i[ADDRW-1:MEM_ADDRW];

    spram_lane_align u_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_data_i),
        .mask_o     (mask_s),
        .wdata_o    (wdata_al_s),
        .rdata_o    (load_s)
    );

    // Size encoding 3 behaves as a word access.
    always_comb begin
        if (req_size_i == 2'b11) begin
            size_norm_s = MEM_WORD;
        end else begin
            size_norm_s = mem_size_e'(req_size_i);
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i[MEM_ADDRW-1:0];
                    we_d    = req_we_i;
                    size_d  = size_norm_s;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    rdata_d = {DATAW{1'b0}};
                    err_d   = 1'b0;
`ifdef SPRAM_INITIATOR_MISALIGN_CHK_EN
                    if (is_misaligned(size_norm_s, req_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    // Misaligned offsets are truncated to the natural boundary.
                    case (size_norm_s)
                        MEM_HALF: addr_d[0]   = 1'b0;
                        MEM_WORD: addr_d[1:0] = 2'b00;
                        default:  addr_d      = req_addr_i[MEM_ADDRW-1:0];
                    endcase
                    state_d = ISSUE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE, WAIT: begin
                if (mem_resp_i) begin
                    rdata_d = we_q ? {DATAW{1'b0}} : load_s;
                    state_d = RSP;
                end else begin
                    state_d = WAIT;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= {MEM_ADDRW{1'b0}};
            we_q    <= 1'b0;
            size_q  <= MEM_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= {DATAW{1'b0}};
            rdata_q <= {DATAW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs are only non-zero during the single ISSUE cycle.
    assign issue_s     = (state_q == ISSUE);
    assign mem_valid_o = issue_s;
    assign mem_we_o    = issue_s & we_q;
    assign mem_addr_o  = issue_s ? {addr_q[MEM_ADDRW-1:2], 2'b00} : {MEM_ADDRW{1'b0}};
    assign mem_mask_o  = issue_s ? (we_q ? mask_s : 4'b1111) : 4'b0000;
    assign mem_data_o  = (issue_s & we_q) ? wdata_al_s : {DATAW{1'b0}};

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_spram_initiator.sv
// Scoreboard bench for spram_initiator against a behavioural spram (both response modes).
module tb_spram_initiator;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_mask_o;
    logic        mem_we_o;
    logic        mem_valid_o;
    logic [31:0] mem_data_i;
    logic        mem_resp_i;

    spram_initiator dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_mask_o     (mem_mask_o),
        .mem_we_o       (mem_we_o),
        .mem_valid_o    (mem_valid_o),
        .mem_data_i     (mem_data_i),
        .mem_resp_i     (mem_resp_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural spram: en_pipe selects registered (+1) or same-cycle response.
    logic        en_pipe    = 1'b1;
    logic        hold_resp  = 1'b0;
    logic        stale_resp = 1'b0;
    logic [31:0] mem [0:255] = '{default: 32'h0};
    logic        resp_q = 1'b0;
    logic [31:0] rd_q   = 32'h0;

    always @(posedge clk_i) begin
        if (mem_valid_o && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
            end
        end
        resp_q <= mem_valid_o & ~hold_resp;
        rd_q   <= mem[mem_addr_o[9:2]];
    end

    assign mem_resp_i = stale_resp | (en_pipe ? resp_q : (mem_valid_o & ~hold_resp));
    assign mem_data_i = en_pipe ? rd_q : mem[mem_addr_o[9:2]];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t        dq[$];
    logic [32:0] sb_q[$];
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          rsp_cnt  = 0;
    int          mv_cnt   = 0;
    int          mv_cyc   = 0;
    int          rsp_rise_cyc = 0;
    logic [31:0] mv_addr, mv_data;
    logic [3:0]  mv_mask;
    logic        mv_we;

    // Monitor: the only process that compares and steps the counters.
    initial begin : monitor
        chk_t        c;
        logic [32:0] e;
        logic        rsp_prev;
        rsp_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            while (dq.size() != 0) begin
                c = dq.pop_front();
                chk_cnt++;
                if (c.act === c.exp) pass_cnt++;
                else $display("FAIL %s: actual 0x%08h required 0x%08h", c.nm, c.act, c.exp);
            end
            if (mem_valid_o) begin
                mv_cnt++;
                mv_cyc  = cyc;
                mv_addr = 32'(mem_addr_o);
                mv_data = mem_data_o;
                mv_mask = mem_mask_o;
                mv_we   = mem_we_o;
            end
            if (rsp_valid_o && !rsp_prev) rsp_rise_cyc = cyc;
            rsp_prev = rsp_valid_o;
            if (rsp_valid_o && rsp_ready_i) begin
                chk_cnt += 2;
                if (sb_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: actual rdata 0x%08h required no response", rsp_rdata_o);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_rdata_o === e[31:0]) pass_cnt++;
                    else $display("FAIL rsp_rdata: actual 0x%08h required 0x%08h", rsp_rdata_o, e[31:0]);
                    if (rsp_err_o === e[32]) pass_cnt++;
                    else $display("FAIL rsp_err: actual %0b required %0b", rsp_err_o, e[32]);
                end
                rsp_cnt++;
            end
        end
    end

    int n_issued = 0;
    int acc_cyc  = 0;
    int mv_base  = 0;

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.nm  = nm;
        c.act = act;
        c.exp = exp;
        dq.push_back(c);
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input logic [32:0] exp);
        req_valid_i    = 1'b1;
        req_addr_i     = addr;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wd;
        sb_q.push_back(exp);
        n_issued++;
        acc_cyc = cyc;
        mv_base = mv_cnt;
        @(posedge clk_i);
        #1;
        req_valid_i    = 1'b0;
        req_addr_i     = 32'hFFFF_FFFF;
        req_we_i       = ~we;
        req_size_i     = 2'b00;
        req_unsigned_i = ~uns;
        req_wdata_i    = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_cnt < n_issued && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        post("rsp_done", 32'(rsp_cnt >= n_issued), 32'd1);
    endtask

    task automatic xact(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input logic [32:0] exp);
        issue(addr, we, size, uns, wd, exp);
        wait_rsp();
    endtask

    task automatic run_pass();
        int n;
        int lat_rsp;
        lat_rsp = en_pipe ? 3 : 2;

        // Byte store and sign/zero-extended byte loads, with latency checks.
        xact(32'h5, 1'b1, SZ_B, 1'b0, 32'h0000_00AB, {1'b0, 32'h0});
        post("st_b_mask", 32'(mv_mask), 32'h2);
        post("st_b_data", mv_data, 32'h0000_AB00);
        post("st_b_addr", mv_addr, 32'h4);
        post("st_b_we", 32'(mv_we), 32'd1);
        post("lat_mv", 32'(mv_cyc - acc_cyc), 32'd1);
        post("mv_once", 32'(mv_cnt - mv_base), 32'd1);
        post("lat_rsp", 32'(rsp_rise_cyc - acc_cyc), 32'(lat_rsp));
        xact(32'h5, 1'b0, SZ_B, 1'b0, 32'h0, {1'b0, 32'hFFFF_FFAB});
        post("ld_b_mask", 32'(mv_mask), 32'hF);
        post("ld_b_we", 32'(mv_we), 32'd0);
        post("ld_lat_rsp", 32'(rsp_rise_cyc - acc_cyc), 32'(lat_rsp));
        xact(32'h5, 1'b0, SZ_B, 1'b1, 32'h0, {1'b0, 32'h0000_00AB});

        // Word store, half/byte loads from its lanes, half store, size 3.
        xact(32'h10, 1'b1, SZ_W, 1'b0, 32'h1234_5678, {1'b0, 32'h0});
        post("st_w_mask", 32'(mv_mask), 32'hF);
        xact(32'h12, 1'b0, SZ_H, 1'b0, 32'h0, {1'b0, 32'h0000_1234});
        xact(32'h10, 1'b0, SZ_H, 1'b0, 32'h0, {1'b0, 32'h0000_5678});
        xact(32'h13, 1'b0, SZ_B, 1'b0, 32'h0, {1'b0, 32'h0000_0012});
        xact(32'h1A, 1'b1, SZ_H, 1'b0, 32'h0000_BEEF, {1'b0, 32'h0});
        post("st_h_mask", 32'(mv_mask), 32'hC);
        post("st_h_data", mv_data, 32'hBEEF_0000);
        xact(32'h1A, 1'b0, SZ_H, 1'b0, 32'h0, {1'b0, 32'hFFFF_BEEF});
        xact(32'h1A, 1'b0, SZ_H, 1'b1, 32'h0, {1'b0, 32'h0000_BEEF});
        xact(32'h10, 1'b0, 2'b11, 1'b0, 32'h0, {1'b0, 32'h1234_5678});

        // Response back-pressure: everything held, no re-issue.
        rsp_ready_i = 1'b0;
        issue(32'h10, 1'b0, SZ_W, 1'b0, 32'h0, {1'b0, 32'h1234_5678});
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        post("hold_reach", 32'(rsp_valid_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            post("hold_valid", 32'(rsp_valid_o), 32'd1);
            post("hold_rdata", rsp_rdata_o, 32'h1234_5678);
            post("hold_req_rdy", 32'(req_ready_o), 32'd0);
        end
        post("hold_no_mv", 32'(mv_cnt - mv_base), 32'd1);
        rsp_ready_i = 1'b1;
        wait_rsp();

        // Misaligned word load.
`ifdef SPRAM_INITIATOR_MISALIGN_CHK_EN
        xact(32'h6, 1'b0, SZ_W, 1'b0, 32'h0, {1'b1, 32'h0});
        post("mis_no_mv", 32'(mv_cnt - mv_base), 32'd0);
        post("mis_lat", 32'(rsp_rise_cyc - acc_cyc), 32'd1);
`else
        xact(32'h6, 1'b0, SZ_W, 1'b0, 32'h0, {1'b0, 32'h0000_AB00});
        post("mis_addr", mv_addr, 32'h4);
        post("mis_mv", 32'(mv_cnt - mv_base), 32'd1);
`endif

        // Reset while waiting on the memory abandons the access.
        hold_resp = 1'b1;
        issue(32'h10, 1'b0, SZ_W, 1'b0, 32'h0, {1'b0, 32'h1234_5678});
        repeat (3) @(posedge clk_i);
        #1;
        post("wait_busy", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        void'(sb_q.pop_back());
        n_issued--;
        post("rst_req_rdy", 32'(req_ready_o), 32'd1);
        post("rst_rsp_vld", 32'(rsp_valid_o), 32'd0);
        post("rst_mem_vld", 32'(mem_valid_o), 32'd0);
        post("rst_rdata", rsp_rdata_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        hold_resp  = 1'b0;
        stale_resp = 1'b1;
        @(posedge clk_i);
        #1;
        stale_resp = 1'b0;
        post("stale_rsp_vld", 32'(rsp_valid_o), 32'd0);
        post("stale_req_rdy", 32'(req_ready_o), 32'd1);
        post("stale_no_mv", 32'(mv_cnt - mv_base), 32'd1);
        xact(32'h8, 1'b1, SZ_W, 1'b0, 32'hCAFE_F00D, {1'b0, 32'h0});
        xact(32'h8, 1'b0, SZ_W, 1'b0, 32'h0, {1'b0, 32'hCAFE_F00D});
    endtask

    initial begin : stimulus
        rst_i          = 1'b0;
        req_valid_i    = 1'b0;
        req_addr_i     = 32'h0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_wdata_i    = 32'h0;
        rsp_ready_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        post("por_req_rdy", 32'(req_ready_o), 32'd1);
        post("por_rsp_vld", 32'(rsp_valid_o), 32'd0);
        post("por_mem_vld", 32'(mem_valid_o), 32'd0);
        post("por_mem_mask", 32'(mem_mask_o), 32'h0);
        post("por_mem_addr", 32'(mem_addr_o), 32'h0);
        post("por_rsp_err", 32'(rsp_err_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int p = 0; p < 2; p++) begin
            en_pipe = (p == 0);
            run_pass();
        end
        @(posedge clk_i);
        #1;
        post("sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) @(posedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
